veda_lsu_sequencer: RTL and testbench

Load/store initiator that drives the VEDA memory's single read/write port on behalf of the datapath. It accepts load and store burst requests over a valid/ready handshake, sequences them into the memory's `mode`/`write`/address/data signals one word per access, and returns load data and store completions over a valid/ready response channel. It sits between the instruction datapath and the `veda_instruction` memory.

---
 rtl/veda_lsu_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_veda_lsu_sequencer.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/veda_lsu_sequencer.sv
// veda_lsu_sequencer
//
// Load/store initiator for the single read/write port of the VEDA instruction
// memory. Accepts load and store burst requests, sequences them one word per
// memory access and returns load words / store completions on a response channel.
//
// Optional feature: define LSU_BOUNDS_CHECK_EN to reject requests whose burst would
// run past DEPTH-1. A rejected request makes no memory access and answers with
// rsp_err_o=1. Without the macro, addresses wrap modulo DEPTH and rsp_err_o is 0.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   reset_i      synchronous active-high reset
//   req_valid_i  request present            req_ready_o  request accepted (IDLE only)
//   req_op_i     0 = store fill, 1 = load   req_addr_i   start word address
//   req_len_i    burst length minus 1       req_data_i   store fill value
//   rsp_valid_o  response present           rsp_ready_i  consumer accepts response
//   rsp_data_o   load word (0 for stores)   rsp_last_o   final response of request
//   rsp_err_o    request rejected
//   mem_wdata_o  memory data input (a)      mem_waddr_o  memory write address (b)
//   mem_raddr_o  memory read address (c)    mem_mode_o   0 = write, 1 = read
//   mem_write_o  memory access enable       mem_rdata_i  memory output, 1 cycle latency

module veda_lsu_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned LEN   = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_op_i,
    input  logic [LEN-1:0]   req_addr_i,
    input  logic [2:0]       req_len_i,
    input  logic [WIDTH-1:0] req_data_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_last_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    output logic [LEN-1:0]   mem_waddr_o,
    output logic [LEN-1:0]   mem_raddr_o,
    output logic             mem_mode_o,
    output logic             mem_write_o,
    input  logic [WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        StIdle,
        StStore,
        StRdIssue,
        StRdWait,
        StResp
    } state_e;

    state_e           state_q, state_d;
    logic [LEN-1:0]   addr_q, addr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] fill_q, fill_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_last_q, rsp_last_d;
    // Memory-side address/data/mode registers: they hold the last driven value
    // whenever the port is not being accessed.
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [LEN-1:0]   waddr_q, waddr_d;
    logic [LEN-1:0]   raddr_q, raddr_d;
    logic             mode_q, mode_d;
    logic [LEN-1:0]   addr_nxt;

`ifdef LSU_BOUNDS_CHECK_EN
    logic             err_q, err_d;
    logic [LEN:0]     start_ext;
    logic [LEN:0]     end_ext;
    logic             req_oob;

    // One extra bit so start + len cannot overflow before the compare.
    assign start_ext = {1'b0, req_addr_i};
    assign end_ext   = start_ext + (LEN + 1)'(req_len_i);
    assign req_oob   = (start_ext >= (LEN + 1)'(DEPTH)) || (end_ext >= (LEN + 1)'(DEPTH));
`endif

    // Word address increment, wrapping at the top of memory.
    assign addr_nxt = (addr_q == LEN'(DEPTH - 1)) ? '0 : addr_q + LEN'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        wdata_d     = wdata_q;
        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        mode_d      = mode_q;
        mem_write_o = 1'b0;
`ifdef LSU_BOUNDS_CHECK_EN
        err_d       = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i % LEN'(DEPTH);
                    cnt_d   = {1'b0, req_len_i} + 4'd1;
                    fill_d  = req_data_i;
                    state_d = req_op_i ? StRdIssue : StStore;
`ifdef LSU_BOUNDS_CHECK_EN
                    err_d   = 1'b0;
                    if (req_oob) begin
                        state_d    = StResp;
                        err_d      = 1'b1;
                        rsp_last_d = 1'b1;
                        rsp_data_d = '0;
                        cnt_d      = '0;
                    end
`endif
                end
            end

            StStore: begin
                mem_write_o = 1'b1;
                mode_d      = 1'b0;
                waddr_d     = addr_q;
                wdata_d     = fill_q;
                addr_d      = addr_nxt;
                cnt_d       = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = StResp;
                    rsp_data_d = '0;
                    rsp_last_d = 1'b1;
                end
            end

            StRdIssue: begin
                mem_write_o = 1'b1;
                mode_d      = 1'b1;
                raddr_d     = addr_q;
                state_d     = StRdWait;
            end

            StRdWait: begin
                rsp_data_d = mem_rdata_i;
                rsp_last_d = (cnt_q == 4'd1);
                cnt_d      = cnt_q - 4'd1;
                state_d    = StResp;
            end

            StResp: begin
                if (rsp_ready_i) begin
`ifdef LSU_BOUNDS_CHECK_EN
                    err_d = 1'b0;
`endif
                    // Only loads leave a non-zero count behind after a response.
                    if (cnt_q != 4'd0) begin
                        addr_d  = addr_nxt;
                        state_d = StRdIssue;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            cnt_q      <= '0;
            fill_q     <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
            wdata_q    <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            rsp_data_q <= rsp_data_d;
            rsp_last_q <= rsp_last_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            mode_q     <= mode_d;
        end
    end

`ifdef LSU_BOUNDS_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_last_o  = rsp_last_q;

    // The port shows the current access in the access cycle itself and holds it after.
    assign mem_wdata_o = wdata_d;
    assign mem_waddr_o = waddr_d;
    assign mem_raddr_o = raddr_d;
    assign mem_mode_o  = mode_d;

endmodule

// File: tb/tb_veda_lsu_sequencer.sv
module tb_veda_lsu_sequencer;

    localparam int DEPTH = 32;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_addr;
    logic [2:0]  req_len;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic [31:0] mem_wdata;
    logic [31:0] mem_waddr;
    logic [31:0] mem_raddr;
    logic        mem_mode;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int tests_run;
    int tests_failed;

    // Memory model of the attached veda_instruction memory plus access logs.
    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          rd_addr_q[$];

    veda_lsu_sequencer #(
        .WIDTH(32),
        .DEPTH(DEPTH),
        .LEN  (32)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_op_i   (req_op),
        .req_addr_i (req_addr),
        .req_len_i  (req_len),
        .req_data_i (req_data),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o (rsp_data),
        .rsp_last_o (rsp_last),
        .rsp_err_o  (rsp_err),
        .mem_wdata_o(mem_wdata),
        .mem_waddr_o(mem_waddr),
        .mem_raddr_o(mem_raddr),
        .mem_mode_o (mem_mode),
        .mem_write_o(mem_write),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write === 1'b1) begin
            if (mem_mode === 1'b0) begin
                mem[mem_waddr % DEPTH] <= mem_wdata;
                wr_addr_q.push_back(int'(mem_waddr));
                wr_data_q.push_back(mem_wdata);
            end else begin
                mem_rdata <= mem[mem_raddr % DEPTH];
                rd_addr_q.push_back(int'(mem_raddr));
            end
        end
    end

    // Presents a request at a falling edge; it is taken at the next rising edge.
    // Returns at the falling edge of the first cycle after acceptance.
    task automatic send_req(input logic op, input logic [31:0] addr, input logic [2:0] len,
                            input logic [31:0] data);
        int n = 0;
        req_op    = op;
        req_addr  = addr;
        req_len   = len;
        req_data  = data;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_req_timeout: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Waits (bounded) for one response and consumes it; optional random back-pressure.
    task automatic get_rsp(input bit stall, output logic [31:0] d, output logic l,
                           output logic e, output bit ok);
        bit done = 0;
        ok = 0;
        d  = 'x;
        l  = 'x;
        e  = 'x;
        for (int n = 0; n < 300 && !done; n++) begin
            rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid === 1'b1 && rsp_ready) begin
                d    = rsp_data;
                l    = rsp_last;
                e    = rsp_err;
                ok   = 1;
                done = 1;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({req_ready, rsp_valid, rsp_last, rsp_err} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_handshake: ready/valid/last/err=%b required 1000",
                     {req_ready, rsp_valid, rsp_last, rsp_err});
        end
        tests_run++;
        if (rsp_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_rsp_data: got %0h required 0", rsp_data);
        end
        tests_run++;
        if ({mem_write, mem_mode} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_mem_ctrl: write/mode=%b required 00", {mem_write, mem_mode});
        end
        tests_run++;
        if (mem_waddr !== 32'd0 || mem_raddr !== 32'd0 || mem_wdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mem_bus: waddr=%0h raddr=%0h wdata=%0h required 0",
                     mem_waddr, mem_raddr, mem_wdata);
        end
    endtask

    task automatic test_store_single();
        req_op    = 1'b0;
        req_addr  = 32'd13;
        req_len   = 3'd0;
        req_data  = 32'd134;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        tests_run++;
        if (mem_write !== 1'b1 || mem_mode !== 1'b0 || mem_waddr !== 32'd13
            || mem_wdata !== 32'd134) begin
            tests_failed++;
            $display("FAIL store1_write: write=%b mode=%b b=%0d a=%0d required 1 0 13 134",
                     mem_write, mem_mode, mem_waddr, mem_wdata);
        end
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL store1_early_rsp: rsp_valid=%b required 0", rsp_valid);
        end
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd0 || rsp_last !== 1'b1
            || mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL store1_rsp: valid=%b data=%0d last=%b write=%b required 1 0 1 0",
                     rsp_valid, rsp_data, rsp_last, mem_write);
        end
        ref_mem[13] = 32'd134;
        @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL store1_idle: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] d;
        logic l, e;
        bit ok;
        send_req(1'b0, 32'd10, 3'd1, 32'd144);
        get_rsp(0, d, l, e, ok);
        ref_mem[10] = 32'd144;
        ref_mem[11] = 32'd144;
        tests_run++;
        if (!ok || d !== 32'd0 || l !== 1'b1 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL st_ld_store_rsp: ok=%0d data=%0d last=%b err=%b required 1 0 1 0",
                     ok, d, l, e);
        end
        send_req(1'b1, 32'd10, 3'd1, 32'd0);
        for (int i = 0; i < 2; i++) begin
            get_rsp(0, d, l, e, ok);
            tests_run++;
            if (!ok || d !== 32'd144 || l !== (i == 1) || e !== 1'b0) begin
                tests_failed++;
                $display("FAIL st_ld_load_rsp%0d: ok=%0d data=%0d last=%b err=%b required 144 %0d 0",
                         i, ok, d, l, e, i == 1);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic l, e;
        bit ok;
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        send_req(1'b0, 32'd30, 3'd3, 32'd170);
        get_rsp(0, d, l, e, ok);
`ifdef LSU_BOUNDS_CHECK_EN
        tests_run++;
        if (!ok || d !== 32'd0 || l !== 1'b1 || e !== 1'b1 || wr_addr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wrap_store_err: ok=%0d data=%0d last=%b err=%b writes=%0d required 1 0 1 1 0",
                     ok, d, l, e, wr_addr_q.size());
        end
        send_req(1'b1, 32'd30, 3'd3, 32'd0);
        get_rsp(0, d, l, e, ok);
        tests_run++;
        if (!ok || d !== 32'd0 || l !== 1'b1 || e !== 1'b1 || rd_addr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL wrap_load_err: ok=%0d data=%0d last=%b err=%b reads=%0d required 1 0 1 1 0",
                     ok, d, l, e, rd_addr_q.size());
        end
`else
        tests_run++;
        if (!ok || d !== 32'd0 || l !== 1'b1 || e !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_store_rsp: ok=%0d data=%0d last=%b err=%b required 1 0 1 0",
                     ok, d, l, e);
        end
        tests_run++;
        if (wr_addr_q.size() != 4 || wr_addr_q[0] != 30 || wr_addr_q[1] != 31
            || wr_addr_q[2] != 0 || wr_addr_q[3] != 1 || wr_data_q[3] !== 32'd170) begin
            tests_failed++;
            $display("FAIL wrap_store_addrs: got %p required '{30,31,0,1}", wr_addr_q);
        end
        for (int i = 0; i < 4; i++) ref_mem[(30 + i) % DEPTH] = 32'd170;
        send_req(1'b1, 32'd30, 3'd3, 32'd0);
        for (int i = 0; i < 4; i++) begin
            get_rsp(0, d, l, e, ok);
            tests_run++;
            if (!ok || d !== 32'd170 || l !== (i == 3)) begin
                tests_failed++;
                $display("FAIL wrap_load_rsp%0d: ok=%0d data=%0d last=%b required 170 %0d",
                         i, ok, d, l, i == 3);
            end
        end
        tests_run++;
        if (rd_addr_q.size() != 4 || rd_addr_q[0] != 30 || rd_addr_q[1] != 31
            || rd_addr_q[2] != 0 || rd_addr_q[3] != 1) begin
            tests_failed++;
            $display("FAIL wrap_load_addrs: got %p required '{30,31,0,1}", rd_addr_q);
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] d;
        logic l, e;
        bit ok;
        int n = 0;
        rsp_ready = 1'b0;
        send_req(1'b1, 32'd10, 3'd1, 32'd0);
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'd144 || rsp_last !== 1'b0
                || mem_write !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: valid=%b data=%0d last=%b write=%b required 1 144 0 0",
                         c, rsp_valid, rsp_data, rsp_last, mem_write);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (mem_write !== 1'b1 || mem_mode !== 1'b1 || mem_raddr !== 32'd11) begin
            tests_failed++;
            $display("FAIL stall_next_issue: write=%b mode=%b c=%0d required 1 1 11",
                     mem_write, mem_mode, mem_raddr);
        end
        get_rsp(0, d, l, e, ok);
        tests_run++;
        if (!ok || d !== 32'd144 || l !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_second_rsp: ok=%0d data=%0d last=%b required 1 144 1", ok, d, l);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [31:0] fill;
        logic l, e;
        bit ok;
        send_req(1'b1, 32'd20, 3'd5, 32'd0);
        get_rsp(0, d, l, e, ok);
        tests_run++;
        if (!ok || d !== ref_mem[20] || l !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_first_rsp: ok=%0d data=%0h last=%b required %0h 0",
                     ok, d, l, ref_mem[20]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_idle: valid=%b ready=%b write=%b required 0 1 0",
                     rsp_valid, req_ready, mem_write);
        end
        repeat (4) @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_no_rsp: rsp_valid=%b required 0", rsp_valid);
        end
        fill = $urandom;
        send_req(1'b0, 32'd5, 3'd0, fill);
        get_rsp(0, d, l, e, ok);
        ref_mem[5] = fill;
        send_req(1'b1, 32'd5, 3'd0, 32'd0);
        get_rsp(0, d, l, e, ok);
        tests_run++;
        if (!ok || d !== fill || l !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_after_reset: ok=%0d data=%0h last=%b required %0h 1", ok, d, l, fill);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic        op;
            int          addr;
            int          len;
            logic [31:0] data;
            bit          stall;
            bit          exp_err;
            logic [31:0] d;
            logic        l, e;
            bit          ok;
            bit          wr_ok;
            op      = 1'($urandom_range(0, 1));
            addr    = $urandom_range(0, 2 * DEPTH - 1);
            len     = $urandom_range(0, 7);
            data    = $urandom;
            stall   = 1'($urandom_range(0, 1));
            exp_err = 0;
`ifdef LSU_BOUNDS_CHECK_EN
            exp_err = (addr >= DEPTH) || (addr + len >= DEPTH);
`endif
            wr_addr_q.delete();
            wr_data_q.delete();
            send_req(op, addr, 3'(len), data);
            if (exp_err || !op) begin
                get_rsp(stall, d, l, e, ok);
                tests_run++;
                if (!ok || d !== 32'd0 || l !== 1'b1 || e !== exp_err) begin
                    tests_failed++;
                    $display("FAIL rand%0d_done: ok=%0d data=%0h last=%b err=%b required 0 1 %0d",
                             it, ok, d, l, e, exp_err);
                end
                wr_ok = (wr_addr_q.size() == (exp_err ? 0 : len + 1));
                if (wr_ok && !exp_err) begin
                    for (int j = 0; j <= len; j++) begin
                        if (wr_addr_q[j] != (addr + j) % DEPTH || wr_data_q[j] !== data) wr_ok = 0;
                        ref_mem[(addr + j) % DEPTH] = data;
                    end
                end
                tests_run++;
                if (!wr_ok) begin
                    tests_failed++;
                    $display("FAIL rand%0d_writes: got %p required %0d writes from %0d",
                             it, wr_addr_q, exp_err ? 0 : len + 1, addr % DEPTH);
                end
            end else begin
                for (int i = 0; i <= len; i++) begin
                    get_rsp(stall, d, l, e, ok);
                    tests_run++;
                    if (!ok || d !== ref_mem[(addr + i) % DEPTH] || l !== (i == len)
                        || e !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL rand%0d_load%0d: ok=%0d data=%0h last=%b required %0h %0d",
                                 it, i, ok, d, l, ref_mem[(addr + i) % DEPTH], i == len);
                    end
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_op       = 1'b0;
        req_addr     = '0;
        req_len      = '0;
        req_data     = '0;
        rsp_ready    = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        @(negedge clk);
        test_reset();
        test_store_single();
        test_store_load();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
